shift_left_iter: RTL

Iterative, multi-cycle left shifter that complements the combinational right-shift datapath in the ALU. It accepts an operand and a shift amount under a START/DONE handshake and performs one bit position per clock. Each shift is either logical (zero fill) or a rotate. It sits beside the combinational units where a small-area shifter is preferred over a full barrel network.

---
 rtl/shift_left_iter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/shift_left_iter.sv
// -----------------------------------------------------------------------------
// shift_left_iter
//   Iterative left shifter / rotator. One bit position per clock under a
//   START/DONE handshake. Sits beside the combinational ALU units where a
//   small-area shifter is preferred over a full barrel network.
//
//   Optional feature macro: SHIFT_LEFT_CARRY_EN
//     defined   -> CARRY port present, holds the last bit shifted out
//     undefined -> no CARRY port and no carry logic
//
// Parameters
//   Nbits  operand/result width (>= 2)
//
// Ports
//   CLK    in   rising-edge clock
//   RST    in   asynchronous active-high reset
//   START  in   request, sampled only in IDLE
//   TYPE   in   0 = logical shift left (zero fill), 1 = rotate left
//   A      in   operand (latched with START)
//   B      in   unsigned shift amount (latched with START)
//   OUT    out  result register, holds until the next completion
//   BUSY   out  high whenever the FSM is not idle
//   DONE   out  one-cycle completion strobe
//   CARRY  out  last bit shifted out (SHIFT_LEFT_CARRY_EN only)
// -----------------------------------------------------------------------------
module shift_left_iter #(
    parameter int Nbits = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             TYPE,
    input  logic [Nbits-1:0] A,
    input  logic [Nbits-1:0] B,
    output logic [Nbits-1:0] OUT,
    output logic             BUSY,
    output logic             DONE
`ifdef SHIFT_LEFT_CARRY_EN
    ,output logic            CARRY
`endif
);

    localparam int               CW   = $clog2(Nbits + 1);
    localparam logic [Nbits-1:0] NB_V = Nbits'(Nbits);
    localparam logic [CW-1:0]    ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [Nbits-1:0] work;
    logic             typ;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    n_eff;
    logic [Nbits-1:0] work_shl;

    // Effective shift count: a logical shift saturates at Nbits (everything
    // is gone by then), a rotate only matters modulo the width.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        n_eff = '0;
        if (TYPE)
            n_eff = CW'(B % NB_V);
        else if (B >= NB_V)
            n_eff = CW'(NB_V);
        else
            n_eff = CW'(B);
    end

    // One-position step; the fill bit is zero or the MSB wrapping around.
    assign work_shl = {work[Nbits-2:0], (typ ? work[Nbits-1] : 1'b0)};

    // ---------------------------------------------------------------- FSM
    // State register plus the registered BUSY/DONE outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= S_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = (n_eff != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (cnt == ONE) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state, so BUSY/DONE come straight out of
    // flops aligned with the state they describe.
    always_comb begin
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            work <= '0;
            typ  <= 1'b0;
            cnt  <= '0;
            OUT  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        work <= A;
                        typ  <= TYPE;
                        cnt  <= n_eff;
                        // Zero-length operation completes with the operand.
                        if (n_eff == '0)
                            OUT <= A;
                    end
                end
                S_SHIFT: begin
                    work <= work_shl;
                    cnt  <= cnt - ONE;
                    if (cnt == ONE)
                        OUT <= work_shl;
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_LEFT_CARRY_EN
    // The bit leaving the MSB on the final step is A[Nbits-n] for a logical
    // shift and, for a rotate, the bit that lands in OUT[0]; both are
    // work[Nbits-1] just before that step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CARRY <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (START && (n_eff == '0)) CARRY <= 1'b0;
                S_SHIFT: if (cnt == ONE) CARRY <= work[Nbits-1];
                default: ;
            endcase
        end
    end
`endif

endmodule
